pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stage-control for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). Replaces the fixed stage_decode sequencing.
//  Tracks per-stage valid bits and generates stage load enables. Handles I/D cache-miss freeze, load-use bubbles and
//  redirect squash at a configurable resolve stage, plus EX operand forwarding selects and saturating perf counters.
// PARAMETERS
//  REG_AW          5  register-index width
//  FWD_EN          1  1: MEM/WB->EX forwarding; 0: interlock-only (fwd selects forced 00)
//  REDIRECT_STAGE  3  stage resolving branch/jump: 2=EX, 3=MEM; other values are a $fatal at elaboration
//  CNT_W          32  perf-counter width
// PORTS
//  clk             in   1       clock
//  rst             in   1       synchronous, active-high reset
//  inst_read       in   1       I-cache request outstanding
//  inst_resp       in   1       I-cache response
//  data_read       in   1       D-cache read request (MEM stage)
//  data_write      in   1       D-cache write request (MEM stage)
//  data_resp       in   1       D-cache response
//  id_rs1,id_rs2   in   REG_AW  ID source registers
//  id_use_rs1/rs2  in   1       ID instruction reads rs1/rs2
//  ex_rd,mem_rd,wb_rd in REG_AW destination per stage
//  ex_wr,mem_wr,wb_wr in 1      stage writes regfile (control.load_regfile)
//  ex_is_load      in   1       EX holds a load
//  redirect        in   1       resolve stage takes branch/jal/jalr
//  load_pc         out  1       PC update enable
//  load_decode/execute/memory/writeback out 1  stage register enables
//  valid_d,valid_e,valid_m,valid_wb out 1  stage valid bits; valid_wb gates regfile write and commit
//  fwd_a_sel,fwd_b_sel out 2    00 regfile, 01 MEM alu result, 10 WB regfilemux result
//  stall_cnt       out  CNT_W   cycles lost to freeze or load-use
//  flush_cnt       out  CNT_W   accepted redirects
// BEHAVIOUR
//  Reset: all valid_*=0, counters=0. Load enables and fwd selects are combinational; with all valids=0 they are 00.
//  Producers (ex/mem/wb *_wr) count only when the matching valid_* is 1 and rd!=0. Redirect counts only if valid at REDIRECT_STAGE.
//  freeze = (inst_read&~inst_resp) | ((data_read|data_write)&~data_resp). All loads=0 and valids hold.
//    Freeze has priority over all other events.
//  luse: FWD_EN=1 -> valid EX load whose rd matches a used ID source.
//    FWD_EN=0 -> any valid EX/MEM/WB producer matches a used ID source.
//  Priority when ~freeze: redirect > luse > advance.
//  Advance: all loads=1; valid_d<=1, valid_e<=valid_d, valid_m<=valid_e, valid_wb<=valid_m.
//  luse: load_pc=load_decode=0, rest=1. valid_d held, valid_e<=0 (bubble), older stages shift.
//  redirect: load_pc=1 (datapath selects target), all loads=1. Clear valids younger than resolver.
//    REDIRECT_STAGE=3 -> valid_d,valid_e,valid_m<=0; valid_wb<=valid_m.
//    REDIRECT_STAGE=2 -> valid_d,valid_e<=0; valid_m<=valid_e.
//  Resolver commits normally. Redirect and luse in the same cycle: redirect only; luse is not counted.
//  Forwarding (EX operand, per source): match valid MEM producer -> 01, else valid WB -> 10, else 00.
//    MEM wins over WB. rd=0 never forwards.
//  Counters: stall_cnt +1 per freeze or luse cycle; flush_cnt +1 per accepted redirect.
//    Both saturate at 2^CNT_W-1, no wrap.
//  rst mid-operation: next edge returns to reset state regardless of outstanding cache handshakes.
// STRUCTURE
//  rv32i_types gains fwd_sel_t enum (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10) and pipe_stage_t (ST_EX=2, ST_MEM=3).
//  Sub-module fwd_select (combinational, instantiated twice for A/B): inputs src, mem/wb rd, wr, valid; output fwd_sel_t.
//  Valid bits and counters live in the top module.
// TESTING
//  Reset then 4 back-to-back ALU ops, all resp=1:
//    -> valids fill 1,1,1,1 by cycle 4; all loads=1 each cycle; stall_cnt=0.
//  add x5 in MEM, sub reading x5 in EX; add x5 in WB, other x5 reader in EX:
//    -> fwd_a_sel=01 for the first; 10 for the second; x0 producer -> 00.
//  lw x6 in EX, ID reads x6 (FWD_EN=1):
//    -> one cycle with load_pc=load_decode=0, valid_e=0 next; stall_cnt=1; then fwd_a_sel=10.
//  data_read=1, data_resp low 3 cycles:
//    -> loads=0 and valids frozen for 3 cycles; stall_cnt=3. Redirect raised during freeze: no flush until resp.
//  Taken branch in MEM (REDIRECT_STAGE=3), same-cycle luse:
//    -> load_pc=1; valid_d/e/m=0 next; valid_wb=1; flush_cnt=1; stall_cnt unchanged. Repeat with REDIRECT_STAGE=2.
//  CNT_W=4, 20 freeze cycles -> stall_cnt holds 15. rst asserted mid-freeze -> all valids/counters 0 next edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the RV32I pipeline stage controller: forwarding selects
// and stage indices used to pick the branch resolve point.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } pipe_stage_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stage controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    import pipe_hazard_ctrl_pkg::*;

    logic              inst_read, inst_resp;
    logic              data_read, data_write, data_resp;
    logic [REG_AW-1:0] id_rs1, id_rs2;
    logic              id_use_rs1, id_use_rs2;
    logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
    logic              ex_wr, mem_wr, wb_wr;
    logic              ex_is_load;
    logic              redirect;
    logic              load_pc, load_decode, load_execute, load_memory, load_writeback;
    logic              valid_d, valid_e, valid_m, valid_wb;
    fwd_sel_t          fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    modport master (
        output inst_read, inst_resp, data_read, data_write, data_resp,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_rd, mem_rd, wb_rd, ex_wr, mem_wr, wb_wr, ex_is_load, redirect,
        input  load_pc, load_decode, load_execute, load_memory, load_writeback,
               valid_d, valid_e, valid_m, valid_wb, fwd_a_sel, fwd_b_sel,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  inst_read, inst_resp, data_read, data_write, data_resp,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_rd, mem_rd, wb_rd, ex_wr, mem_wr, wb_wr, ex_is_load, redirect,
        output load_pc, load_decode, load_execute, load_memory, load_writeback,
               valid_d, valid_e, valid_m, valid_wb, fwd_a_sel, fwd_b_sel,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Per-operand EX forwarding mux select: nearest valid producer wins, x0 never forwards.
module fwd_select
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wr,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wr,
    input  logic              wb_valid,
    output fwd_sel_t          sel
);

    always_comb begin
        sel = FWD_RF;
        if (src != '0) begin
            if (mem_valid && mem_wr && (src == mem_rd))
                sel = FWD_MEM;
            else if (wb_valid && wb_wr && (src == wb_rd))
                sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage controller for the 5-stage RV32I pipe: valid tracking, load enables,
// cache-miss freeze, load-use bubbles, redirect squash, forwarding, perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter bit FWD_EN         = 1'b1,
    parameter int REDIRECT_STAGE = 3,
    parameter int CNT_W          = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    if (REDIRECT_STAGE != int'(ST_EX) && REDIRECT_STAGE != int'(ST_MEM)) begin : g_bad_stage
        $fatal(1, "pipe_hazard_ctrl: REDIRECT_STAGE must be 2 (EX) or 3 (MEM)");
    end

    logic              valid_d, valid_e, valid_m, valid_wb;
    logic [REG_AW-1:0] ex_rs1, ex_rs2;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    logic              freeze, luse, resolver_valid, take_redirect, take_luse;
    logic              ex_prod, mem_prod, wb_prod;
    logic              load_pc, load_decode, load_rest;
    fwd_sel_t          fwd_a, fwd_b;

    function automatic logic src_hit(input logic [REG_AW-1:0] rs, input logic en,
                                     input logic [REG_AW-1:0] rd);
        return en && (rs == rd);
    endfunction

    assign ex_prod  = valid_e  && bus.ex_wr  && (bus.ex_rd  != '0);
    assign mem_prod = valid_m  && bus.mem_wr && (bus.mem_rd != '0);
    assign wb_prod  = valid_wb && bus.wb_wr  && (bus.wb_rd  != '0);

    assign freeze = (bus.inst_read && !bus.inst_resp) ||
                    ((bus.data_read || bus.data_write) && !bus.data_resp);

    // With forwarding only a load in EX can't be bypassed; without it any in-flight writer interlocks.
    always_comb begin
        luse = 1'b0;
        if (FWD_EN) begin
            luse = ex_prod && bus.ex_is_load &&
                   (src_hit(bus.id_rs1, bus.id_use_rs1, bus.ex_rd) ||
                    src_hit(bus.id_rs2, bus.id_use_rs2, bus.ex_rd));
        end else begin
            luse = (ex_prod  && (src_hit(bus.id_rs1, bus.id_use_rs1, bus.ex_rd)  ||
                                 src_hit(bus.id_rs2, bus.id_use_rs2, bus.ex_rd)))  ||
                   (mem_prod && (src_hit(bus.id_rs1, bus.id_use_rs1, bus.mem_rd) ||
                                 src_hit(bus.id_rs2, bus.id_use_rs2, bus.mem_rd))) ||
                   (wb_prod  && (src_hit(bus.id_rs1, bus.id_use_rs1, bus.wb_rd)  ||
                                 src_hit(bus.id_rs2, bus.id_use_rs2, bus.wb_rd)));
        end
    end

    assign resolver_valid = (REDIRECT_STAGE == int'(ST_MEM)) ? valid_m : valid_e;
    assign take_redirect  = !freeze && bus.redirect && resolver_valid;
    assign take_luse      = !freeze && !take_redirect && luse;

    always_comb begin
        load_pc     = 1'b1;
        load_decode = 1'b1;
        load_rest   = 1'b1;
        if (freeze) begin
            load_pc     = 1'b0;
            load_decode = 1'b0;
            load_rest   = 1'b0;
        end else if (take_luse) begin
            load_pc     = 1'b0;
            load_decode = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d  <= 1'b0;
            valid_e  <= 1'b0;
            valid_m  <= 1'b0;
            valid_wb <= 1'b0;
        end else if (freeze) begin
            valid_d  <= valid_d;
        end else if (take_redirect) begin
            // Squash everything younger than the resolver; the resolver itself retires.
            valid_d  <= 1'b0;
            valid_e  <= 1'b0;
            valid_m  <= (REDIRECT_STAGE == int'(ST_MEM)) ? 1'b0 : valid_e;
            valid_wb <= valid_m;
        end else if (take_luse) begin
            valid_e  <= 1'b0;
            valid_m  <= valid_e;
            valid_wb <= valid_m;
        end else begin
            valid_d  <= 1'b1;
            valid_e  <= valid_d;
            valid_m  <= valid_e;
            valid_wb <= valid_m;
        end
    end

    // EX-stage source indices follow the instruction into EX for forwarding.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else if (load_rest) begin
            ex_rs1 <= bus.id_rs1;
            ex_rs2 <= bus.id_rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((freeze || take_luse) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (take_redirect && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src(ex_rs1), .mem_rd(bus.mem_rd), .mem_wr(bus.mem_wr), .mem_valid(valid_m),
        .wb_rd(bus.wb_rd), .wb_wr(bus.wb_wr), .wb_valid(valid_wb), .sel(fwd_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src(ex_rs2), .mem_rd(bus.mem_rd), .mem_wr(bus.mem_wr), .mem_valid(valid_m),
        .wb_rd(bus.wb_rd), .wb_wr(bus.wb_wr), .wb_valid(valid_wb), .sel(fwd_b)
    );

    assign bus.fwd_a_sel      = FWD_EN ? fwd_a : FWD_RF;
    assign bus.fwd_b_sel      = FWD_EN ? fwd_b : FWD_RF;
    assign bus.load_pc        = load_pc;
    assign bus.load_decode    = load_decode;
    assign bus.load_execute   = load_rest;
    assign bus.load_memory    = load_rest;
    assign bus.load_writeback = load_rest;
    assign bus.valid_d        = valid_d;
    assign bus.valid_e        = valid_e;
    assign bus.valid_m        = valid_m;
    assign bus.valid_wb       = valid_wb;
    assign bus.stall_cnt      = stall_cnt;
    assign bus.flush_cnt      = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: two controllers (MEM-resolve with forwarding, EX-resolve interlock-only)
// share one stimulus stream; each step checks hand-computed enables, valids, selects, counters.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       inst_read, inst_resp, data_read, data_write, data_resp;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_wr, mem_wr, wb_wr, ex_is_load, redirect;

    int vectors = 0;
    int miscompares = 0;

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4)) b3 ();
    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4)) b2 ();

    assign b3.inst_read = inst_read;   assign b2.inst_read = inst_read;
    assign b3.inst_resp = inst_resp;   assign b2.inst_resp = inst_resp;
    assign b3.data_read = data_read;   assign b2.data_read = data_read;
    assign b3.data_write = data_write; assign b2.data_write = data_write;
    assign b3.data_resp = data_resp;   assign b2.data_resp = data_resp;
    assign b3.id_rs1 = id_rs1;         assign b2.id_rs1 = id_rs1;
    assign b3.id_rs2 = id_rs2;         assign b2.id_rs2 = id_rs2;
    assign b3.id_use_rs1 = id_use_rs1; assign b2.id_use_rs1 = id_use_rs1;
    assign b3.id_use_rs2 = id_use_rs2; assign b2.id_use_rs2 = id_use_rs2;
    assign b3.ex_rd = ex_rd;           assign b2.ex_rd = ex_rd;
    assign b3.mem_rd = mem_rd;         assign b2.mem_rd = mem_rd;
    assign b3.wb_rd = wb_rd;           assign b2.wb_rd = wb_rd;
    assign b3.ex_wr = ex_wr;           assign b2.ex_wr = ex_wr;
    assign b3.mem_wr = mem_wr;         assign b2.mem_wr = mem_wr;
    assign b3.wb_wr = wb_wr;           assign b2.wb_wr = wb_wr;
    assign b3.ex_is_load = ex_is_load; assign b2.ex_is_load = ex_is_load;
    assign b3.redirect = redirect;     assign b2.redirect = redirect;

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .REDIRECT_STAGE(3), .CNT_W(4)) u3 (
        .clk(clk), .rst(rst), .bus(b3.slave)
    );
    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .REDIRECT_STAGE(2), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .bus(b2.slave)
    );

    // {load_pc, load_decode, load_execute, load_memory, load_writeback}, {valid_d, valid_e, valid_m, valid_wb}
    logic [4:0] ld3, ld2;
    logic [3:0] vl3, vl2;
    assign ld3 = {b3.load_pc, b3.load_decode, b3.load_execute, b3.load_memory, b3.load_writeback};
    assign ld2 = {b2.load_pc, b2.load_decode, b2.load_execute, b2.load_memory, b2.load_writeback};
    assign vl3 = {b3.valid_d, b3.valid_e, b3.valid_m, b3.valid_wb};
    assign vl2 = {b2.valid_d, b2.valid_e, b2.valid_m, b2.valid_wb};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_read = 1'b1; inst_resp = 1'b1;
        data_read = 1'b0; data_write = 1'b0; data_resp = 1'b1;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = '0; mem_rd = '0; wb_rd = '0;
        ex_wr = 1'b0; mem_wr = 1'b0; wb_wr = 1'b0;
        ex_is_load = 1'b0; redirect = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic fill();
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        idle();
        do_reset();

        // reset state
        chk("rst_valid", vl3, 4'b0000);
        chk("rst_stall", b3.stall_cnt, 0);
        chk("rst_flush", b3.flush_cnt, 0);
        chk("rst_fwd_a", b3.fwd_a_sel, 2'b00);
        chk("rst_loads", ld3, 5'b11111);

        // four ALU ops stream in
        chk("fill_loads0", ld3, 5'b11111); tick(); chk("fill_v1", vl3, 4'b1000);
        chk("fill_loads1", ld3, 5'b11111); tick(); chk("fill_v2", vl3, 4'b1100);
        chk("fill_loads2", ld3, 5'b11111); tick(); chk("fill_v3", vl3, 4'b1110);
        chk("fill_loads3", ld3, 5'b11111); tick(); chk("fill_v4", vl3, 4'b1111);
        chk("fill_stall", b3.stall_cnt, 0);

        // forwarding: EX reads x5 (A) and x7 (B)
        id_rs1 = 5'd5; id_rs2 = 5'd7;
        tick();
        mem_rd = 5'd5; mem_wr = 1'b1;
        #1 chk("fwd_a_mem", b3.fwd_a_sel, 2'b01);
        chk("fwd_b_none", b3.fwd_b_sel, 2'b00);
        mem_wr = 1'b0; wb_rd = 5'd5; wb_wr = 1'b1;
        #1 chk("fwd_a_wb", b3.fwd_a_sel, 2'b10);
        mem_wr = 1'b1; wb_rd = 5'd7;
        #1 chk("fwd_a_mem_wins", b3.fwd_a_sel, 2'b01);
        chk("fwd_b_wb", b3.fwd_b_sel, 2'b10);
        mem_rd = 5'd5; wb_rd = 5'd5;
        #1 chk("fwd_a_mem_over_wb", b3.fwd_a_sel, 2'b01);
        id_rs1 = '0; mem_wr = 1'b0; wb_wr = 1'b0;
        tick();
        mem_rd = '0; mem_wr = 1'b1; wb_rd = '0; wb_wr = 1'b1;
        #1 chk("fwd_a_x0", b3.fwd_a_sel, 2'b00);
        idle();

        // load-use: lw x6 in EX, ID reads x6
        ex_rd = 5'd6; ex_wr = 1'b1; ex_is_load = 1'b1;
        id_rs1 = 5'd6; id_use_rs1 = 1'b1;
        #1 chk("luse_loads", ld3, 5'b00111);
        tick();
        chk("luse_valid", vl3, 4'b1011);
        chk("luse_stall", b3.stall_cnt, 1);
        ex_rd = '0; ex_wr = 1'b0; ex_is_load = 1'b0;
        mem_rd = 5'd6; mem_wr = 1'b1;
        #1 chk("luse_release_loads", ld3, 5'b11111);
        tick();
        chk("luse_after_valid", vl3, 4'b1101);
        mem_wr = 1'b0; wb_rd = 5'd6; wb_wr = 1'b1;
        #1 chk("luse_fwd_wb", b3.fwd_a_sel, 2'b10);
        chk("luse_stall_hold", b3.stall_cnt, 1);
        idle();
        tick(); tick();
        chk("refill_valid", vl3, 4'b1111);

        // D-cache miss: 3 frozen cycles, redirect raised mid-freeze
        data_read = 1'b1; data_resp = 1'b0;
        #1 chk("frz_loads", ld3, 5'b00000);
        tick(); chk("frz_v1", vl3, 4'b1111);
        redirect = 1'b1;
        tick(); chk("frz_v2", vl3, 4'b1111); chk("frz_flush2", b3.flush_cnt, 0);
        tick(); chk("frz_v3", vl3, 4'b1111); chk("frz_flush3", b3.flush_cnt, 0);
        chk("frz_stall", b3.stall_cnt, 4);
        data_resp = 1'b1;
        #1 chk("frz_rel_loads", ld3, 5'b11111);
        tick();
        chk("frz_rel_valid", vl3, 4'b0001);
        chk("frz_rel_flush", b3.flush_cnt, 1);
        chk("frz_rel_stall", b3.stall_cnt, 4);
        idle();

        // redirect with same-cycle load-use, both resolve stages
        do_reset();
        fill();
        chk("br_pre_v3", vl3, 4'b1111);
        chk("br_pre_v2", vl2, 4'b1111);
        redirect = 1'b1;
        ex_rd = 5'd6; ex_wr = 1'b1; ex_is_load = 1'b1;
        id_rs1 = 5'd6; id_use_rs1 = 1'b1;
        #1 chk("br_loads3", ld3, 5'b11111);
        chk("br_loads2", ld2, 5'b11111);
        tick();
        chk("br_valid3", vl3, 4'b0001);
        chk("br_valid2", vl2, 4'b0011);
        chk("br_flush3", b3.flush_cnt, 1);
        chk("br_flush2", b2.flush_cnt, 1);
        chk("br_stall3", b3.stall_cnt, 0);
        chk("br_stall2", b2.stall_cnt, 0);
        // redirect with an invalid resolver is ignored
        ex_wr = 1'b0; ex_is_load = 1'b0; id_use_rs1 = 1'b0;
        tick();
        chk("br_inv_valid3", vl3, 4'b1000);
        chk("br_inv_valid2", vl2, 4'b1001);
        chk("br_inv_flush3", b3.flush_cnt, 1);
        chk("br_inv_flush2", b2.flush_cnt, 1);
        idle();

        // interlock-only instance stalls on a MEM producer and never forwards
        do_reset();
        id_rs2 = 5'd9;
        fill();
        mem_rd = 5'd9; mem_wr = 1'b1;
        #1 chk("il_fwd_b3", b3.fwd_b_sel, 2'b01);
        chk("il_fwd_b2", b2.fwd_b_sel, 2'b00);
        id_use_rs2 = 1'b1;
        #1 chk("il_loads2", ld2, 5'b00111);
        chk("il_loads3", ld3, 5'b11111);
        tick();
        chk("il_stall2", b2.stall_cnt, 1);
        chk("il_stall3", b3.stall_cnt, 0);
        chk("il_valid2", vl2, 4'b1011);
        idle();

        // counter saturation, then reset in the middle of a freeze
        data_read = 1'b1; data_resp = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall3", b3.stall_cnt, 15);
        chk("sat_stall2", b2.stall_cnt, 15);
        chk("sat_valid2", vl2, 4'b1011);
        rst = 1'b1;
        tick();
        chk("midrst_valid3", vl3, 4'b0000);
        chk("midrst_valid2", vl2, 4'b0000);
        chk("midrst_stall3", b3.stall_cnt, 0);
        chk("midrst_stall2", b2.stall_cnt, 0);
        chk("midrst_flush3", b3.flush_cnt, 0);
        rst = 1'b0;
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
